pcie_sipo_align: RTL and testbench

// - Receive-side 8b/10b symbol deserializer for the PCIe PHY. It is the counterpart of the TX parallel-to-serial shifter.
// - Shifts in one serial bit per enabled clock, MSB first. Finds the symbol boundary from K28.5 comma symbols.
// - Presents aligned 10-bit symbols, with a valid strobe, to the downstream 8b/10b decoder.
// - Declares lock after repeated aligned commas. Drops lock after repeated misaligned commas.

---
 rtl/pcie_phy_pkg.sv | 14 +
 rtl/pcie_comma_detect.sv | 14 +
 rtl/pcie_sipo_align.sv | 178 +++++++++++++++++
 tb/tb_pcie_sipo_align.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: K28.5 comma encodings and the symbol-alignment state type.
package pcie_phy_pkg;

    localparam int unsigned SYM_W     = 10;
    localparam logic [9:0]  K28_5_NEG = 10'b0011111010;
    localparam logic [9:0]  K28_5_POS = 10'b1100000101;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECK    = 2'd1,
        LOCKED   = 2'd2
    } align_state_t;

endpackage

// File: rtl/pcie_comma_detect.sv
// Combinational K28.5 matcher: flags a candidate symbol equal to either comma disparity.
module pcie_comma_detect
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic [DATA_WIDTH-1:0] i_sym,
    output logic                  o_comma_hit
);

    assign o_comma_hit = (i_sym == DATA_WIDTH'(K28_5_NEG)) ||
                         (i_sym == DATA_WIDTH'(K28_5_POS));

endmodule

// File: rtl/pcie_sipo_align.sv
// Serial-to-parallel 8b/10b symbol deserializer with K28.5-based boundary alignment and lock tracking.
module pcie_sipo_align
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  is_comma,
    output logic                  locked,
    output logic                  align_err
);

    localparam int CNT_W  = $clog2(DATA_WIDTH);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W  = $clog2(LOSS_COUNT + 1);

    logic [DATA_WIDTH-1:0] r_sr;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [GOOD_W-1:0]     r_good_cnt;
    logic [ERR_W-1:0]      r_err_cnt;
    align_state_t          r_state;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_is_comma;
    logic                  r_locked;
    logic                  r_align_err;

    logic [DATA_WIDTH-1:0] w_sr_next;
    logic                  w_comma_hit;
    logic                  w_boundary;
    logic [DATA_WIDTH-1:0] w_sr_upd;
    logic [CNT_W-1:0]      w_bit_cnt_next;
    logic [GOOD_W-1:0]     w_good_next;
    logic [ERR_W-1:0]      w_err_next;
    align_state_t          w_state_next;
    logic                  w_emit;
    logic                  w_align_err;

    assign w_sr_next  = {r_sr[DATA_WIDTH-2:0], data_in};
    assign w_boundary = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

    pcie_comma_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_comma_detect (
        .i_sym       (w_sr_next),
        .o_comma_hit (w_comma_hit)
    );

    // Next-state, counter and emit decisions; everything holds while enable is low.
    always_comb begin
        w_sr_upd       = r_sr;
        w_bit_cnt_next = r_bit_cnt;
        w_good_next    = r_good_cnt;
        w_err_next     = r_err_cnt;
        w_state_next   = r_state;
        w_emit         = 1'b0;
        w_align_err    = 1'b0;
        if (enable) begin
            w_sr_upd = w_sr_next;
            case (r_state)
                UNLOCKED: begin
                    if (w_comma_hit) begin
                        w_emit         = 1'b1;
                        w_bit_cnt_next = '0;
                        w_good_next    = GOOD_W'(1);
                        w_err_next     = '0;
                        w_state_next   = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt;
                    end
                end
                CHECK: begin
                    if (w_boundary) begin
                        w_emit         = 1'b1;
                        w_bit_cnt_next = '0;
                        if (w_comma_hit) begin
                            if (r_good_cnt >= GOOD_W'(LOCK_COUNT - 1)) begin
                                w_good_next  = GOOD_W'(LOCK_COUNT);
                                w_err_next   = '0;
                                w_state_next = LOCKED;
                            end else begin
                                w_good_next = r_good_cnt + GOOD_W'(1);
                            end
                        end else begin
                            w_good_next = r_good_cnt;
                        end
                    end else if (w_comma_hit) begin
                        // Comma off the assumed boundary: trust the new comma and restart counting.
                        w_align_err    = 1'b1;
                        w_emit         = 1'b1;
                        w_bit_cnt_next = '0;
                        w_good_next    = GOOD_W'(1);
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
                        w_emit         = 1'b1;
                        w_bit_cnt_next = '0;
                        if (w_comma_hit) begin
                            w_err_next = '0;
                        end else begin
                            w_err_next = r_err_cnt;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                        if (w_comma_hit) begin
                            w_align_err = 1'b1;
                            if (r_err_cnt >= ERR_W'(LOSS_COUNT - 1)) begin
                                w_err_next   = ERR_W'(LOSS_COUNT);
                                w_state_next = UNLOCKED;
                            end else begin
                                w_err_next = r_err_cnt + ERR_W'(1);
                            end
                        end else begin
                            w_err_next = r_err_cnt;
                        end
                    end
                end
                default: begin
                    w_bit_cnt_next = '0;
                    w_good_next    = '0;
                    w_err_next     = '0;
                    w_state_next   = UNLOCKED;
                end
            endcase
        end else begin
            w_sr_upd = r_sr;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_good_cnt   <= '0;
            r_err_cnt    <= '0;
            r_state      <= UNLOCKED;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_is_comma   <= 1'b0;
            r_locked     <= 1'b0;
            r_align_err  <= 1'b0;
        end else begin
            r_sr         <= w_sr_upd;
            r_bit_cnt    <= w_bit_cnt_next;
            r_good_cnt   <= w_good_next;
            r_err_cnt    <= w_err_next;
            r_state      <= w_state_next;
            r_data_valid <= w_emit;
            r_align_err  <= w_align_err;
            r_locked     <= (w_state_next == LOCKED);
            if (w_emit) begin
                r_data_out <= w_sr_next;
                r_is_comma <= w_comma_hit;
            end else begin
                r_data_out <= r_data_out;
                r_is_comma <= r_is_comma;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign is_comma   = r_is_comma;
    assign locked     = r_locked;
    assign align_err  = r_align_err;

endmodule

// File: tb/tb_pcie_sipo_align.sv
// Self-checking bench for pcie_sipo_align: directed scenarios plus random traffic against a bit-stream reference model.
module tb_pcie_sipo_align;

    localparam int W    = 10;
    localparam int LOCK = 3;
    localparam int LOSS = 4;
    localparam int K_NEG = 10'h0FA;
    localparam int K_POS = 10'h305;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         data_in;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         is_comma;
    logic         locked;
    logic         align_err;

    pcie_sipo_align #(
        .DATA_WIDTH (W),
        .LOCK_COUNT (LOCK),
        .LOSS_COUNT (LOSS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .is_comma   (is_comma),
        .locked     (locked),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int vld_cnt = 0;
    int aerr_cnt = 0;

    // Reference model: last W bits as an integer, bits since boundary, acquisition mode.
    int m_win, m_phase, m_good, m_err;
    int m_mode;            // 0 searching, 1 checking, 2 locked
    int e_dout, e_valid, e_comma, e_aerr;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit b);
        bit comma;
        bit at_bnd;
        e_valid = 0;
        e_aerr  = 0;
        if (r) begin
            m_win = 0; m_phase = 0; m_good = 0; m_err = 0; m_mode = 0;
            e_dout = 0; e_comma = 0;
        end else if (en) begin
            m_win  = (m_win * 2 + int'(b)) % (1 << W);
            comma  = (m_win == K_NEG) || (m_win == K_POS);
            m_phase = m_phase + 1;
            at_bnd = (m_phase == W);
            if (m_mode == 0) begin
                if (comma) begin
                    e_valid = 1; e_dout = m_win; e_comma = 1;
                    m_phase = 0; m_good = 1; m_err = 0;
                    m_mode = (LOCK == 1) ? 2 : 1;
                end
            end else if (m_mode == 1) begin
                if (at_bnd) begin
                    e_valid = 1; e_dout = m_win; e_comma = int'(comma);
                    m_phase = 0;
                    if (comma) begin
                        m_good = (m_good + 1 > LOCK) ? LOCK : m_good + 1;
                        if (m_good >= LOCK) begin
                            m_mode = 2; m_err = 0;
                        end
                    end
                end else if (comma) begin
                    e_aerr = 1;
                    e_valid = 1; e_dout = m_win; e_comma = 1;
                    m_phase = 0; m_good = 1;
                end
            end else begin
                if (at_bnd) begin
                    e_valid = 1; e_dout = m_win; e_comma = int'(comma);
                    m_phase = 0;
                    if (comma) m_err = 0;
                end else if (comma) begin
                    e_aerr = 1;
                    m_err = (m_err + 1 > LOSS) ? LOSS : m_err + 1;
                    if (m_err >= LOSS) m_mode = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit b);
        @(negedge clk);
        reset   = r;
        enable  = en;
        data_in = b;
        @(posedge clk);
        #1;
        model_step(r, en, b);
        chk_eq("data_valid", 32'(data_valid), 32'(e_valid));
        chk_eq("align_err",  32'(align_err),  32'(e_aerr));
        chk_eq("locked",     32'(locked),     32'(m_mode == 2));
        chk_eq("data_out",   32'(data_out),   32'(e_dout));
        chk_eq("is_comma",   32'(is_comma),   32'(e_comma));
        if (data_valid === 1'b1) vld_cnt++;
        if (align_err === 1'b1) aerr_cnt++;
    endtask

    task automatic send_bits(input logic [W-1:0] s, input int first, input int last);
        for (int i = first; i >= last; i--) cyc(1'b0, 1'b1, s[i]);
    endtask

    task automatic send_sym(input logic [W-1:0] s);
        send_bits(s, W - 1, 0);
    endtask

    task automatic send_sym_rand_en(input logic [W-1:0] s);
        for (int i = W - 1; i >= 0; i--) begin
            while ($urandom_range(0, 9) == 0) cyc(1'b0, 1'b0, 1'($urandom));
            cyc(1'b0, 1'b1, s[i]);
        end
    endtask

    initial begin
        logic [W-1:0] sym;
        reset = 1'b1; enable = 1'b0; data_in = 1'b0;

        // 1: reset with random inputs, then idle zeros
        repeat (3) cyc(1'b1, 1'($urandom), 1'($urandom));
        vld_cnt = 0;
        repeat (20) cyc(1'b0, 1'b1, 1'b0);
        chk_eq("t1_no_valid", 32'(vld_cnt), 32'd0);
        chk_eq("t1_unlocked", 32'(locked), 32'd0);

        // 2: junk bits, then comma/data sequence until lock
        cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1);
        send_sym(W'(K_NEG));
        chk_eq("t2_first_valid", 32'(data_valid), 32'd1);
        chk_eq("t2_first_comma", 32'(is_comma), 32'd1);
        send_sym(10'h2AA);
        chk_eq("t2_d2aa", 32'(data_out), 32'h2AA);
        send_sym(W'(K_POS));
        chk_eq("t2_not_yet_locked", 32'(locked), 32'd0);
        send_sym(10'h155);
        chk_eq("t2_d155", 32'(data_out), 32'h155);
        send_sym(W'(K_NEG));
        chk_eq("t2_locked", 32'(locked), 32'd1);
        chk_eq("t2_valid_count", 32'(vld_cnt), 32'd5);

        // 3: enable gap mid-symbol
        send_bits(10'h2AA, 9, 6);
        repeat (5) cyc(1'b0, 1'b0, 1'($urandom));
        send_bits(10'h2AA, 5, 0);
        chk_eq("t3_sym_valid", 32'(data_valid), 32'd1);
        chk_eq("t3_sym_data", 32'(data_out), 32'h2AA);
        send_sym(W'(K_NEG));
        chk_eq("t3_still_locked", 32'(locked), 32'd1);

        // 4: one-bit slip, four misaligned commas lose lock, then relock on new boundary
        aerr_cnt = 0;
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < LOSS; i++) begin
            send_sym(W'(K_NEG));
            chk_eq("t4_err_pulse", 32'(align_err), 32'd1);
            chk_eq("t4_lock_state", 32'(locked), 32'(i < LOSS - 1));
        end
        chk_eq("t4_err_count", 32'(aerr_cnt), 32'(LOSS));
        send_sym(W'(K_NEG));
        chk_eq("t4_reacq_valid", 32'(data_valid), 32'd1);
        chk_eq("t4_reacq_unlocked", 32'(locked), 32'd0);
        send_sym(W'(K_NEG));
        send_sym(W'(K_NEG));
        chk_eq("t4_relocked", 32'(locked), 32'd1);
        chk_eq("t4_err_count_final", 32'(aerr_cnt), 32'(LOSS));

        // 5: misaligned comma while checking with two good commas
        repeat (2) cyc(1'b1, 1'b1, 1'($urandom));
        repeat (12) cyc(1'b0, 1'b1, 1'b0);
        send_sym(W'(K_NEG));
        send_sym(10'h2AA);
        send_sym(W'(K_NEG));
        aerr_cnt = 0;
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        send_sym(W'(K_NEG));
        chk_eq("t5_err_pulse", 32'(align_err), 32'd1);
        chk_eq("t5_realign_emit", 32'(data_valid), 32'd1);
        chk_eq("t5_unlocked", 32'(locked), 32'd0);
        send_sym(10'h155);
        send_sym(W'(K_NEG));
        chk_eq("t5_good_restarted", 32'(locked), 32'd0);
        send_sym(W'(K_NEG));
        chk_eq("t5_locked", 32'(locked), 32'd1);

        // 6: reset mid-symbol while locked
        send_bits(10'h2AA, 9, 6);
        cyc(1'b1, 1'b1, 1'($urandom));
        chk_eq("t6_locked", 32'(locked), 32'd0);
        chk_eq("t6_valid", 32'(data_valid), 32'd0);
        chk_eq("t6_dout", 32'(data_out), 32'd0);
        send_bits(10'h2AA, 5, 0);
        send_sym(W'(K_NEG));
        chk_eq("t6_reacq_unlocked", 32'(locked), 32'd0);
        send_sym(W'(K_POS));
        send_sym(W'(K_NEG));
        chk_eq("t6_relocked", 32'(locked), 32'd1);

        // 7: random mix of commas, data, slips, enable gaps and rare resets
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5: send_sym_rand_en(($urandom_range(0, 1) == 0) ? W'(K_NEG) : W'(K_POS));
                6, 7, 8, 9, 10, 11, 12, 13: begin
                    sym = W'($urandom);
                    send_sym_rand_en(sym);
                end
                14, 15: repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b1, 1'($urandom));
                16, 17: repeat ($urandom_range(1, 6)) cyc(1'b0, 1'b0, 1'($urandom));
                18: repeat ($urandom_range(1, 9)) cyc(1'b0, 1'b1, 1'($urandom));
                default: cyc(1'b1, 1'($urandom), 1'($urandom));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
